// File: rtl/spike_scheduler.sv
// Axon-event scheduler: buffers spikes in a ring of per-tick delay slots
// and drains the current slot to neuron_controller one axon at a time.
module spike_scheduler #(
  parameter int AXON_COUNT = 256,
  parameter int NUM_SLOTS  = 16,
  parameter int AXON_W     = $clog2(AXON_COUNT),
  parameter int DELAY_W    = $clog2(NUM_SLOTS)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               tick,
  input  logic               pkt_valid,
  input  logic [AXON_W-1:0]  pkt_axon,
  input  logic [DELAY_W-1:0] pkt_delay,
  output logic [AXON_W-1:0]  from_sched,
  output logic               flag_from_sched,
  input  logic               ctrl_done,
  output logic               busy,
  output logic [DELAY_W-1:0] cur_slot,
  output logic               dropped_packet,
  output logic               tick_overrun
);

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    WAIT
  } state_t;

  localparam logic [AXON_W-1:0] LAST = AXON_W'(AXON_COUNT - 1);

  state_t               state, state_n;
  logic [AXON_COUNT-1:0] slots [NUM_SLOTS];
  logic [AXON_W-1:0]    idx, idx_n;
  logic [DELAY_W-1:0]   slot_n;
  logic [DELAY_W-1:0]   target;
  logic                 pending, pending_n;
  logic                 hit;
  logic                 issue;
  logic                 overrun_n;
  logic                 drop_n;

  // NUM_SLOTS is a power of two, so the add wraps the ring for free
  assign target = cur_slot + pkt_delay;
  assign hit    = slots[cur_slot][idx];
  assign busy   = (state != IDLE) | pending;
  assign drop_n = pkt_valid & (pkt_delay == '0);

  // Next-state, scan index, slot pointer and tick bookkeeping
  always_comb begin
    state_n   = state;
    idx_n     = idx;
    slot_n    = cur_slot;
    pending_n = pending;
    issue     = 1'b0;
    overrun_n = 1'b0;
    unique case (state)
      IDLE: begin
        if (tick | pending) begin
          slot_n    = cur_slot + 1'b1;
          idx_n     = '0;
          // a fresh tick landing on the pending-service cycle is kept
          pending_n = tick & pending;
          state_n   = SCAN;
        end
      end
      SCAN: begin
        if (hit) begin
          issue   = 1'b1;
          state_n = WAIT;
        end else if (idx == LAST) begin
          state_n = IDLE;
        end else begin
          idx_n = idx + 1'b1;
        end
      end
      WAIT: begin
        // done in the issue cycle itself belongs to no issue of ours
        if (ctrl_done & ~flag_from_sched) begin
          if (idx == LAST) begin
            state_n = IDLE;
          end else begin
            idx_n   = idx + 1'b1;
            state_n = SCAN;
          end
        end
      end
      default: state_n = IDLE;
    endcase
    if ((state != IDLE) & tick) begin
      if (pending) overrun_n = 1'b1;
      else         pending_n = 1'b1;
    end
  end

  // Control registers and registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state           <= IDLE;
      idx             <= '0;
      cur_slot        <= '0;
      pending         <= 1'b0;
      from_sched      <= '0;
      flag_from_sched <= 1'b0;
      dropped_packet  <= 1'b0;
      tick_overrun    <= 1'b0;
    end else begin
      state           <= state_n;
      idx             <= idx_n;
      cur_slot        <= slot_n;
      pending         <= pending_n;
      if (issue) from_sched <= idx;
      flag_from_sched <= issue;
      dropped_packet  <= drop_n;
      tick_overrun    <= overrun_n;
    end
  end

  // Slot bitmaps: clear the issued bit, OR in accepted packets
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_SLOTS; i++) slots[i] <= '0;
    end else begin
      if (issue) slots[cur_slot][idx] <= 1'b0;
      if (pkt_valid & (pkt_delay != '0)) slots[target][pkt_axon] <= 1'b1;
    end
  end

endmodule
